and_circuit_sweep_ctrl: RTL and testbench



---
 rtl/and_circuit_sweep_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_and_circuit_sweep_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_circuit_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// and_circuit_sweep_ctrl
//
// Exhaustive-sweep sequencer for the 9-input / 4-control / 5-output AND-gate
// circuit block. For every selected control-pin configuration it drives all
// 2^N_IN input vectors. It waits SETTLE cycles after applying each vector,
// then folds the circuit's result bits into a 16-bit MISR signature.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle sweep request (honoured only when idle)
//   abort      in   terminate sweep; beats every other event
//   cfg_mask   in   [3:0] control bits to enumerate (latched on start)
//   cfg_fixed  in   [3:0] values of the non-enumerated control bits
//   res_in     in   [N_OUT-1:0] circuit outputs {t,n,r,k,m}
//   vec_out    out  [N_IN-1:0] circuit inputs a..i (bit 0 = a)
//   ctrl_out   out  [3:0] circuit controls in1..in4 (bit 0 = in1)
//   busy       out  sweep in progress
//   done       out  one-cycle completion pulse
//   signature  out  [15:0] MISR result, held until the next start
//   vec_cnt    out  [13:0] vectors sampled in the current/last sweep
//
// Optional build macro SWEEP_TRACE_EN adds:
//   trace_valid out  one pulse per sampled vector
//   trace_data  out  {ctrl_out, vec_out, res_in} captured at that sample
// ---------------------------------------------------------------------------
module and_circuit_sweep_ctrl #(
  parameter int          N_IN     = 9,
  parameter int          N_OUT    = 5,
  parameter int          SETTLE   = 2,
  parameter logic [15:0] SIG_SEED = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [3:0]                cfg_mask,
  input  logic [3:0]                cfg_fixed,
  input  logic [N_OUT-1:0]          res_in,
  output logic [N_IN-1:0]           vec_out,
  output logic [3:0]                ctrl_out,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               signature,
`ifdef SWEEP_TRACE_EN
  output logic                      trace_valid,
  output logic [4+N_IN+N_OUT-1:0]   trace_data,
`endif
  output logic [13:0]               vec_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // With no settle interval a vector is sampled in the cycle right after it
  // is applied, so the SETTLE state is skipped entirely.
  localparam logic [1:0] S_AFTER_VEC = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  localparam int            SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? (SETTLE - 1) : 0);

  localparam logic [15:0] MISR_POLY = 16'h1021;

  logic [1:0]      r_state;
  logic [SW-1:0]   r_settle_cnt;
  logic [3:0]      r_mask;
  logic [3:0]      r_fixed;
  logic [3:0]      r_cfg_cnt;
  logic [N_IN-1:0] r_vec;
  logic [3:0]      r_ctrl;
  logic            r_busy;
  logic            r_done;
  logic [15:0]     r_sig;
  logic [13:0]     r_vec_cnt;
`ifdef SWEEP_TRACE_EN
  logic                    r_trace_valid;
  logic [4+N_IN+N_OUT-1:0] r_trace_data;
`endif

  logic        w_vec_last;
  logic        w_cfg_last;
  logic [3:0]  w_cfg_cnt_next;
  logic [15:0] w_sig_next;

  assign w_vec_last = &r_vec;
  assign w_cfg_last = (r_cfg_cnt == r_mask);

  // Forcing the non-enumerated bits to 1 before the increment lets the carry
  // ripple straight through them, so only subsets of the mask are visited,
  // in ascending order.
  assign w_cfg_cnt_next = ((r_cfg_cnt | ~r_mask) + 4'd1) & r_mask;

  assign w_sig_next = {r_sig[14:0], 1'b0}
                    ^ (r_sig[15] ? MISR_POLY : 16'h0000)
                    ^ {{(16-N_OUT){1'b0}}, res_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_mask       <= 4'd0;
      r_fixed      <= 4'd0;
      r_cfg_cnt    <= 4'd0;
      r_vec        <= '0;
      r_ctrl       <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sig        <= 16'h0000;
      r_vec_cnt    <= 14'd0;
`ifdef SWEEP_TRACE_EN
      r_trace_valid <= 1'b0;
      r_trace_data  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef SWEEP_TRACE_EN
      r_trace_valid <= 1'b0;
`endif
      if (abort) begin
        // Partial signature and count are kept for post-mortem inspection.
        r_state      <= S_IDLE;
        r_settle_cnt <= '0;
        r_busy       <= 1'b0;
        r_vec        <= '0;
        r_ctrl       <= 4'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_mask       <= cfg_mask;
              r_fixed      <= cfg_fixed;
              r_cfg_cnt    <= 4'd0;
              r_vec        <= '0;
              r_ctrl       <= cfg_fixed & ~cfg_mask;
              r_sig        <= SIG_SEED;
              r_vec_cnt    <= 14'd0;
              r_settle_cnt <= '0;
              r_busy       <= 1'b1;
              r_state      <= S_AFTER_VEC;
            end
          end

          S_SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_settle_cnt <= '0;
              r_state      <= S_SAMPLE;
            end else begin
              r_settle_cnt <= r_settle_cnt + SW'(1);
            end
          end

          S_SAMPLE: begin
            r_sig     <= w_sig_next;
            r_vec_cnt <= r_vec_cnt + 14'd1;
`ifdef SWEEP_TRACE_EN
            r_trace_valid <= 1'b1;
            r_trace_data  <= {r_ctrl, r_vec, res_in};
`endif
            if (!w_vec_last) begin
              r_vec   <= r_vec + 1'b1;
              r_state <= S_AFTER_VEC;
            end else if (!w_cfg_last) begin
              r_vec     <= '0;
              r_cfg_cnt <= w_cfg_cnt_next;
              r_ctrl    <= (r_fixed & ~r_mask) | (w_cfg_cnt_next & r_mask);
              r_state   <= S_AFTER_VEC;
            end else begin
              // Done is registered on entry so it is high exactly while in DONE.
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end

          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign vec_out   = r_vec;
  assign ctrl_out  = r_ctrl;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_sig;
  assign vec_cnt   = r_vec_cnt;
`ifdef SWEEP_TRACE_EN
  assign trace_valid = r_trace_valid;
  assign trace_data  = r_trace_data;
`endif

endmodule

// File: tb/tb_and_circuit_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_and_circuit_sweep_ctrl
//
// Directed bench for and_circuit_sweep_ctrl. Two instances are used: u_dut2
// (SETTLE=2) and u_dut0 (SETTLE=0). Signatures are checked against a bench
// model that enumerates configurations independently of the RTL counter.
// Latency is the number of rising edges from the edge that samples start to
// the first rising edge at which done is high.
// ---------------------------------------------------------------------------
module tb_and_circuit_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start0, start2;
  logic        abort;
  logic [3:0]  cfg_mask, cfg_fixed;
  logic        res_mode2;
  logic        flip_en;

  logic [4:0]  res0, res2;
  logic [8:0]  vec0, vec2;
  logic [3:0]  ctrl0, ctrl2;
  logic        busy0, busy2, done0, done2;
  logic [15:0] sig0, sig2;
  logic [13:0] cnt0, cnt2;
`ifdef SWEEP_TRACE_EN
  logic        tv0, tv2;
  logic [17:0] td0, td2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- bench model of the AND-gate circuit ----------------
  function automatic logic [4:0] and_model(input logic [8:0] v, input logic [3:0] c);
    logic m, k, r, n, t;
    m = v[0] & v[1] & c[0];
    k = v[2] & v[3] & c[1];
    r = v[4] & v[5] & c[2];
    n = v[6] & v[7] & c[3];
    t = v[8] & v[0] & v[2];
    return {t, n, r, k, m};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [4:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'd0, r};
  endfunction

  // Configurations are visited in ascending control-value order among those
  // whose non-enumerated bits equal the fixed value.
  function automatic logic [15:0] model_sig(input logic [3:0] mask, input logic [3:0] fixed,
                                            input bit use_and, input bit flip);
    logic [15:0] s;
    logic [4:0]  r;
    logic [3:0]  cc;
    logic [8:0]  vv;
    s = 16'hFFFF;
    for (int c = 0; c < 16; c++) begin
      cc = 4'(c);
      if (((cc ^ fixed) & ~mask) == 4'd0) begin
        for (int v = 0; v < 512; v++) begin
          vv = 9'(v);
          r  = use_and ? and_model(vv, cc) : 5'd0;
          if (flip && vv == 9'h0A5 && cc == 4'h3) r = r ^ 5'b00001;
          s = misr_step(s, r);
        end
      end
    end
    return s;
  endfunction

  assign res2 = res_mode2 ? and_model(vec2, ctrl2) : 5'd0;
  assign res0 = and_model(vec0, ctrl0)
              ^ ((flip_en && vec0 == 9'h0A5 && ctrl0 == 4'h3) ? 5'b00001 : 5'b00000);

  and_circuit_sweep_ctrl #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
    .cfg_mask(cfg_mask), .cfg_fixed(cfg_fixed), .res_in(res2),
    .vec_out(vec2), .ctrl_out(ctrl2), .busy(busy2), .done(done2),
    .signature(sig2),
`ifdef SWEEP_TRACE_EN
    .trace_valid(tv2), .trace_data(td2),
`endif
    .vec_cnt(cnt2)
  );

  and_circuit_sweep_ctrl #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .cfg_mask(cfg_mask), .cfg_fixed(cfg_fixed), .res_in(res0),
    .vec_out(vec0), .ctrl_out(ctrl0), .busy(busy0), .done(done0),
    .signature(sig0),
`ifdef SWEEP_TRACE_EN
    .trace_valid(tv0), .trace_data(td0),
`endif
    .vec_cnt(cnt0)
  );

  // Observation mux: sel_fast picks the SETTLE=0 instance.
  logic        sel_fast;
  logic [8:0]  obs_vec;
  logic [3:0]  obs_ctrl;
  logic        obs_busy, obs_done;
  logic [15:0] obs_sig;
  logic [13:0] obs_cnt;
  assign obs_vec  = sel_fast ? vec0  : vec2;
  assign obs_ctrl = sel_fast ? ctrl0 : ctrl2;
  assign obs_busy = sel_fast ? busy0 : busy2;
  assign obs_done = sel_fast ? done0 : done2;
  assign obs_sig  = sel_fast ? sig0  : sig2;
  assign obs_cnt  = sel_fast ? cnt0  : cnt2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("  ok   %-22s = %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- sweep monitor state ----------------
  logic [3:0]  ctrl_seq[$];
  int          pair_cnt[16];
  logic [15:0] prev_pair;
  logic [8:0]  prev_vec;
  bit          mon_first;
  int          n_vec_inc;
  int          n_ctrl_off;
  logic [3:0]  mon_fixed;

  task automatic mon_reset(input logic [3:0] fixed);
    ctrl_seq.delete();
    for (int i = 0; i < 16; i++) pair_cnt[i] = 0;
    prev_pair  = 16'hFFFF;
    prev_vec   = 9'd0;
    mon_first  = 1'b1;
    n_vec_inc  = 0;
    n_ctrl_off = 0;
    mon_fixed  = fixed;
  endtask

  task automatic mon_sample();
    logic [15:0] pair;
    pair = {3'b000, obs_ctrl, obs_vec};
    if (obs_busy) begin
      if (pair != prev_pair) pair_cnt[obs_ctrl]++;
      prev_pair = pair;
      if (ctrl_seq.size() == 0 || ctrl_seq[ctrl_seq.size()-1] != obs_ctrl)
        ctrl_seq.push_back(obs_ctrl);
      if (!mon_first && obs_vec == prev_vec + 9'd1) n_vec_inc++;
      prev_vec  = obs_vec;
      mon_first = 1'b0;
      if (obs_ctrl != mon_fixed) n_ctrl_off++;
    end
  endtask

  // Runs one sweep. lat = latency on done, -1 on timeout, -2 when aborted
  // at the negedge after vec_cnt reached abort_at.
  task automatic run_sweep(input bit fast, input logic [3:0] mask, input logic [3:0] fixed,
                           input int budget, input int extra_start_at, input int abort_at,
                           output int lat);
    lat = -1;
    sel_fast = fast;
    mon_reset(fixed & ~mask);
    @(negedge clk);
    cfg_mask  = mask;
    cfg_fixed = fixed;
    if (fast) start0 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    // Configuration must have been latched; scramble the live inputs.
    cfg_mask  = ~mask;
    cfg_fixed = ~fixed;
    check("busy_after_start", {31'd0, obs_busy}, 32'd1);
    mon_sample();
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      start2 = 1'b0;
      abort  = 1'b0;
      mon_sample();
      if (obs_done) begin
        lat = k + 1;
        break;
      end
      if (abort_at >= 0 && int'(obs_cnt) == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        lat = -2;
        break;
      end
      if (k == extra_start_at) begin
        if (fast) start0 = 1'b1; else start2 = 1'b1;
      end
    end
  endtask

  task automatic check_after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_1cyc"}, {31'd0, obs_done}, 32'd0);
    check({tag, "_busy_low"},  {31'd0, obs_busy}, 32'd0);
  endtask

  int          lat;
  int          n_done_seen;
  logic [15:0] exp_sig;
  logic [15:0] exp_noflip;

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; abort = 1'b0;
    cfg_mask = 4'd0; cfg_fixed = 4'd0; res_mode2 = 1'b0; flip_en = 1'b0;
    sel_fast = 1'b0;
    repeat (3) @(negedge clk);

    // ---- reset state ----
    check("rst_vec2",  {23'd0, vec2},  32'd0);
    check("rst_ctrl2", {28'd0, ctrl2}, 32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    check("rst_done2", {31'd0, done2}, 32'd0);
    check("rst_sig2",  {16'd0, sig2},  32'd0);
    check("rst_cnt2",  {18'd0, cnt2},  32'd0);
    check("rst_sig0",  {16'd0, sig0},  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- SETTLE=2, mask 0, fixed F, zero results ----
    run_sweep(1'b0, 4'h0, 4'hF, 3000, -1, -1, lat);
    check("t1_latency", 32'(lat), 32'd1537);
    check("t1_vec_cnt", {18'd0, obs_cnt}, 32'd512);
    check("t1_ctrl_off", 32'(n_ctrl_off), 32'd0);
    check("t1_ctrl_done", {28'd0, obs_ctrl}, 32'hF);
    exp_sig = model_sig(4'h0, 4'hF, 1'b0, 1'b0);
    check("t1_signature", {16'd0, obs_sig}, {16'd0, exp_sig});
    check_after_done("t1");
    check("t1_vec_held", {23'd0, obs_vec}, 32'h1FF);

    // ---- mask 0101, fixed 0010: four configurations ----
    run_sweep(1'b0, 4'b0101, 4'b0010, 8000, -1, -1, lat);
    check("t2_latency", 32'(lat), 32'd6145);
    check("t2_vec_cnt", {18'd0, obs_cnt}, 32'd2048);
    check("t2_n_cfgs", 32'(ctrl_seq.size()), 32'd4);
    if (ctrl_seq.size() == 4) begin
      check("t2_cfg0", {28'd0, ctrl_seq[0]}, 32'h2);
      check("t2_cfg1", {28'd0, ctrl_seq[1]}, 32'h3);
      check("t2_cfg2", {28'd0, ctrl_seq[2]}, 32'h6);
      check("t2_cfg3", {28'd0, ctrl_seq[3]}, 32'h7);
    end
    check("t2_vecs_cfg2", 32'(pair_cnt[2]), 32'd512);
    check("t2_vecs_cfg3", 32'(pair_cnt[3]), 32'd512);
    check("t2_vecs_cfg6", 32'(pair_cnt[6]), 32'd512);
    check("t2_vecs_cfg7", 32'(pair_cnt[7]), 32'd512);
    exp_sig = model_sig(4'b0101, 4'b0010, 1'b0, 1'b0);
    check("t2_signature", {16'd0, obs_sig}, {16'd0, exp_sig});
    check_after_done("t2");

    // ---- full sweep with AND model, mask F ----
    res_mode2 = 1'b1;
    run_sweep(1'b0, 4'hF, 4'h0, 26000, -1, -1, lat);
    check("t3_latency", 32'(lat), 32'd24577);
    check("t3_vec_cnt", {18'd0, obs_cnt}, 32'd8192);
    exp_noflip = model_sig(4'hF, 4'h0, 1'b1, 1'b0);
    check("t3_signature", {16'd0, obs_sig}, {16'd0, exp_noflip});
    res_mode2 = 1'b0;

    // ---- SETTLE=0, mask F, one result bit flipped in one vector ----
    flip_en = 1'b1;
    run_sweep(1'b1, 4'hF, 4'h0, 9000, -1, -1, lat);
    check("t4_latency", 32'(lat), 32'd8193);
    check("t4_vec_cnt", {18'd0, obs_cnt}, 32'd8192);
    exp_sig = model_sig(4'hF, 4'h0, 1'b1, 1'b1);
    check("t4_signature", {16'd0, obs_sig}, {16'd0, exp_sig});
    check("t4_flip_changes_sig", {31'd0, (obs_sig != exp_noflip)}, 32'd1);
    flip_en = 1'b0;

    // ---- abort at vec_cnt == 100 ----
    run_sweep(1'b0, 4'h0, 4'hF, 2000, -1, 100, lat);
    check("t5_aborted", 32'(lat), 32'hFFFF_FFFE);
    check("t5_busy", {31'd0, obs_busy}, 32'd0);
    check("t5_done", {31'd0, obs_done}, 32'd0);
    check("t5_vec", {23'd0, obs_vec}, 32'd0);
    check("t5_ctrl", {28'd0, obs_ctrl}, 32'd0);
    check("t5_vec_cnt", {18'd0, obs_cnt}, 32'd100);
    exp_sig = 16'hFFFF;
    for (int i = 0; i < 100; i++) exp_sig = misr_step(exp_sig, 5'd0);
    check("t5_partial_sig", {16'd0, obs_sig}, {16'd0, exp_sig});
    n_done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (obs_done) n_done_seen++;
    end
    check("t5_no_done", 32'(n_done_seen), 32'd0);
    run_sweep(1'b0, 4'h0, 4'hF, 3000, -1, -1, lat);
    check("t5_restart_latency", 32'(lat), 32'd1537);
    check("t5_restart_vec_cnt", {18'd0, obs_cnt}, 32'd512);

    // ---- SETTLE=0, mask 0, extra start mid-sweep ----
    run_sweep(1'b1, 4'h0, 4'h5, 1000, 100, -1, lat);
    check("t6_latency", 32'(lat), 32'd513);
    check("t6_vec_cnt", {18'd0, obs_cnt}, 32'd512);
    check("t6_ctrl", {28'd0, obs_ctrl}, 32'h5);
    check("t6_vec_inc_per_cycle", 32'(n_vec_inc), 32'd511);
    check_after_done("t6");

    // ---- reset mid-sweep ----
    sel_fast = 1'b0;
    @(negedge clk);
    cfg_mask = 4'hF; cfg_fixed = 4'h0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (50) @(negedge clk);
    check("t7_busy_before_rst", {31'd0, busy2}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", {31'd0, busy2}, 32'd0);
    check("t7_rst_vec",  {23'd0, vec2},  32'd0);
    check("t7_rst_ctrl", {28'd0, ctrl2}, 32'd0);
    check("t7_rst_sig",  {16'd0, sig2},  32'd0);
    check("t7_rst_cnt",  {18'd0, cnt2},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_idle_after_rst", {31'd0, busy2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
